// File: rtl/led_pkg.sv
// Shared types and constants for the LED pipeline frame-rate measurement blocks.
package led_pkg;

  localparam int                   COUNT_W   = 8;
  localparam logic [COUNT_W-1:0]   COUNT_MAX = 8'hFF;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } meter_state_t;

  // Saturating increment; the frame accumulator must never wrap.
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (v == COUNT_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector; prev resets high so a level already high at reset release is not an edge.
module rise_detect (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic d,
  output logic rise
);

  logic prev_r;

  // Previous-sample register for edge detection
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      prev_r <= 1'b1;
    end else begin
      prev_r <= d;
    end
  end

  assign rise = d & ~prev_r;

endmodule

// File: rtl/frame_rate_meter.sv
// Counts frame_in rising edges per WINDOW_CYCLES-cycle window and publishes a saturated 8-bit rate.
module frame_rate_meter #(
  parameter int WINDOW_CYCLES = 50_000_000
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       frame_in,
  input  logic       hold_in,
  output logic [7:0] count,
  output logic       update_out,
  output logic       overflow_out
);

  import led_pkg::*;

  localparam int               WIN_W    = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [WIN_W-1:0] WIN_ONE  = WIN_W'(1);
  localparam logic [WIN_W-1:0] WIN_ZERO = WIN_W'(0);

  meter_state_t       state_r, state_s;
  logic [WIN_W-1:0]   win_cnt_r, win_cnt_s;
  logic [COUNT_W-1:0] acc_r, acc_s;
  logic               ovf_r, ovf_s;
  logic [COUNT_W-1:0] count_r, count_s;
  logic               overflow_r, overflow_s;
  logic               update_r, update_s;
  logic               edge_s;
  logic               tc_s;
  logic [COUNT_W-1:0] final_cnt_s;
  logic               final_ovf_s;

  rise_detect u_rise_detect (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .d        (frame_in),
    .rise     (edge_s)
  );

  // Window bookkeeping, accumulation and publish decisions
  always_comb begin
    state_s    = state_r;
    win_cnt_s  = win_cnt_r;
    acc_s      = acc_r;
    ovf_s      = ovf_r;
    count_s    = count_r;
    overflow_s = overflow_r;
    update_s   = 1'b0;

    tc_s        = (win_cnt_r == WIN_LAST);
    // An edge on the terminal cycle still belongs to the window that is ending.
    final_cnt_s = edge_s ? sat_inc(acc_r) : acc_r;
    final_ovf_s = ovf_r | (edge_s & (acc_r == COUNT_MAX));

    case (state_r)
      IDLE: begin
        if (edge_s) begin
          state_s   = RUN;
          win_cnt_s = WIN_ONE;
          acc_s     = 8'd1;
          ovf_s     = 1'b0;
        end else begin
          win_cnt_s = WIN_ZERO;
          acc_s     = 8'd0;
          ovf_s     = 1'b0;
        end
      end
      RUN: begin
        if (tc_s) begin
          win_cnt_s = WIN_ZERO;
          acc_s     = 8'd0;
          ovf_s     = 1'b0;
          if (!hold_in) begin
            count_s    = final_cnt_s;
            overflow_s = final_ovf_s;
            update_s   = 1'b1;
          end else begin
            count_s    = count_r;
            overflow_s = overflow_r;
          end
          // A silent window means the stream stopped; wait for the next edge to realign.
          if (final_cnt_s == 8'd0) begin
            state_s = IDLE;
          end else begin
            state_s = RUN;
          end
        end else begin
          win_cnt_s = win_cnt_r + WIN_ONE;
          if (edge_s) begin
            acc_s = sat_inc(acc_r);
            ovf_s = ovf_r | (acc_r == COUNT_MAX);
          end else begin
            acc_s = acc_r;
            ovf_s = ovf_r;
          end
        end
      end
      default: begin
        state_s   = IDLE;
        win_cnt_s = WIN_ZERO;
        acc_s     = 8'd0;
        ovf_s     = 1'b0;
      end
    endcase
  end

  // State, window counter, accumulator and registered outputs
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_r    <= IDLE;
      win_cnt_r  <= WIN_ZERO;
      acc_r      <= 8'd0;
      ovf_r      <= 1'b0;
      count_r    <= 8'd0;
      overflow_r <= 1'b0;
      update_r   <= 1'b0;
    end else begin
      state_r    <= state_s;
      win_cnt_r  <= win_cnt_s;
      acc_r      <= acc_s;
      ovf_r      <= ovf_s;
      count_r    <= count_s;
      overflow_r <= overflow_s;
      update_r   <= update_s;
    end
  end

  assign count        = count_r;
  assign update_out   = update_r;
  assign overflow_out = overflow_r;

endmodule

// File: tb/tb_frame_rate_meter.sv
// Directed-random bench: instance a uses 100-cycle windows, instance b 1000-cycle windows.
module tb_frame_rate_meter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_a, hold_a, frame_b, hold_b;
  logic [7:0] count_a, count_b;
  logic       update_a, update_b, ovf_a, ovf_b;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state per instance (0 = a, 1 = b)
  int exp_cnt [2];
  int exp_ovf [2];
  bit prev_f  [2];
  bit idle_m  [2];
  bit pat [1000];
  int idx [500];

  always #5 clk = ~clk;

  frame_rate_meter #(.WINDOW_CYCLES(100)) dut_a (
    .clk_in(clk), .rst_n_in(rst_n), .frame_in(frame_a), .hold_in(hold_a),
    .count(count_a), .update_out(update_a), .overflow_out(ovf_a)
  );

  frame_rate_meter #(.WINDOW_CYCLES(1000)) dut_b (
    .clk_in(clk), .rst_n_in(rst_n), .frame_in(frame_b), .hold_in(hold_b),
    .count(count_b), .update_out(update_b), .overflow_out(ovf_b)
  );

  task automatic chk(input string tag, input int obs, input int expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input int sel, input string tag, input int exp_upd);
    if (sel == 0) begin
      chk({tag, "_count_a"}, count_a, exp_cnt[0]);
      chk({tag, "_ovf_a"}, ovf_a, exp_ovf[0]);
      chk({tag, "_upd_a"}, update_a, exp_upd);
    end else begin
      chk({tag, "_count_b"}, count_b, exp_cnt[1]);
      chk({tag, "_ovf_b"}, ovf_b, exp_ovf[1]);
      chk({tag, "_upd_b"}, update_b, exp_upd);
    end
  endtask

  // One full measurement window: frame pulses on n even offsets (offset 0 always among them),
  // optionally an extra pulse on the last cycle. Expected rate = number of 0->1 transitions seen.
  task automatic window(input int sel, input int n, input bit tc_edge, input bit hold, input string tag);
    int w, m, need, j, tmp, n_act;
    bit e;
    w = (sel == 0) ? 100 : 1000;
    for (int i = 0; i < w; i++) pat[i] = 1'b0;
    if (n > 0) begin
      pat[0] = 1'b1;
      m    = w / 2 - 1 - (tc_edge ? 1 : 0);
      need = n - 1;
      for (int k = 0; k < m; k++) idx[k] = k + 1;
      for (int k = 0; k < need; k++) begin
        j = $urandom_range(m - 1, k);
        tmp = idx[k]; idx[k] = idx[j]; idx[j] = tmp;
        pat[2 * idx[k]] = 1'b1;
      end
    end
    if (tc_edge) pat[w - 1] = 1'b1;
    n_act = 0;
    for (int i = 0; i < w; i++) begin
      if (sel == 0) begin frame_a = pat[i]; hold_a = hold; end
      else          begin frame_b = pat[i]; hold_b = hold; end
      step();
      e = pat[i] & ~prev_f[sel];
      prev_f[sel] = pat[i];
      if (e) n_act++;
      if (i < w - 1) begin
        if (sel == 0) chk({tag, "_mid_upd_a"}, update_a, 0);
        else          chk({tag, "_mid_upd_b"}, update_b, 0);
      end
    end
    if (!hold) begin
      exp_cnt[sel] = (n_act > 255) ? 255 : n_act;
      exp_ovf[sel] = (n_act > 255) ? 1 : 0;
    end
    chk_outs(sel, tag, hold ? 0 : 1);
    idle_m[sel] = (n_act == 0);
    if (sel == 0) hold_a = 1'b0; else hold_b = 1'b0;
  endtask

  task automatic idle_cycles(input int n, input string tag);
    frame_a = 1'b0;
    frame_b = 1'b0;
    for (int i = 0; i < n; i++) begin
      step();
      chk({tag, "_upd_a"}, update_a, 0);
      chk({tag, "_upd_b"}, update_b, 0);
    end
    prev_f[0] = 1'b0;
    prev_f[1] = 1'b0;
    chk_outs(0, tag, 0);
    chk_outs(1, tag, 0);
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      exp_cnt[s] = 0; exp_ovf[s] = 0; prev_f[s] = 1'b1; idle_m[s] = 1'b1;
    end

    // Reset with frame high through release: no edge, no window.
    rst_n = 1'b0; frame_a = 1'b1; frame_b = 1'b1; hold_a = 1'b0; hold_b = 1'b0;
    repeat (3) step();
    chk_outs(0, "reset", 0);
    chk_outs(1, "reset", 0);
    rst_n = 1'b1;
    for (int i = 0; i < 120; i++) begin
      step();
      chk("no_edge_upd_a", update_a, 0);
      chk("no_edge_count_a", count_a, 0);
    end
    idle_cycles(2, "pre_idle");

    // Saturation on the long-window instance, then recovery and stop.
    window(1, 500, 1'b0, 1'b0, "sat");
    window(1, 3, 1'b0, 1'b0, "after_sat");
    window(1, 0, 1'b0, 1'b0, "b_stop");

    // Basic and randomized windows.
    window(0, 5, 1'b0, 1'b0, "basic");
    for (int r = 0; r < 4; r++) window(0, $urandom_range(50, 1), 1'b0, 1'b0, "rand");

    // Hold freezes the published value.
    window(0, 5, 1'b0, 1'b0, "pre_hold");
    window(0, 9, 1'b0, 1'b1, "hold");
    window(0, 7, 1'b0, 1'b0, "post_hold");

    // Stream stop: empty window publishes 0 then the meter idles until the next edge.
    window(0, 0, 1'b0, 1'b0, "stop");
    idle_cycles(150, "idle");
    window(0, 4, 1'b0, 1'b0, "restart");

    // Edge on the terminal cycle counts in the ending window only.
    window(0, 6, 1'b0, 1'b0, "pre_tc");
    window(0, 6, 1'b1, 1'b0, "tc_edge");
    window(0, 3, 1'b0, 1'b0, "after_tc");

    // Reset in the middle of a window holding 40 frames.
    for (int i = 0; i < 80; i++) begin
      frame_a = (i % 2 == 0);
      step();
      chk("partial_upd_a", update_a, 0);
    end
    frame_a = 1'b0;
    rst_n = 1'b0;
    step();
    for (int s = 0; s < 2; s++) begin
      exp_cnt[s] = 0; exp_ovf[s] = 0; prev_f[s] = 1'b1; idle_m[s] = 1'b1;
    end
    chk_outs(0, "mid_reset", 0);
    rst_n = 1'b1;
    idle_cycles(3, "post_reset");
    window(0, 10, 1'b0, 1'b0, "post_reset_win");
    window(0, $urandom_range(50, 1), 1'b0, 1'b0, "final_rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
